// File: rtl/regfile_scoreboard.sv
// ID-stage register file: two combinational read ports with optional write bypass,
// two write ports and a per-register pending-write scoreboard with a live count.
module regfile_scoreboard #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   output logic              rd_eq,
   output logic              rd_busy1,
   output logic              rd_busy2,
   input  logic              wr_en0,
   input  logic [ADDR_W-1:0] wr_addr0,
   input  logic [DATA_W-1:0] wr_data0,
   input  logic              wr_en1,
   input  logic [ADDR_W-1:0] wr_addr1,
   input  logic [DATA_W-1:0] wr_data1,
   input  logic              iss_en,
   input  logic [ADDR_W-1:0] iss_addr,
   output logic [ADDR_W:0]   busy_cnt
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DEPTH-1:0]  busy_q, busy_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;

   function automatic logic is_zero(input logic [ADDR_W-1:0] a);
      return ZERO_REG && (a == '0);
   endfunction

   function automatic logic wr_hit(input logic [ADDR_W-1:0] a);
      return (wr_en0 && (wr_addr0 == a)) || (wr_en1 && (wr_addr1 == a));
   endfunction

   // Port 1 is applied last so it wins both for bypass and for storage.
   function automatic logic [DATA_W-1:0] read_data(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] d;
      d = regs_q[a];
      if (BYPASS && wr_en0 && (wr_addr0 == a)) d = wr_data0;
      if (BYPASS && wr_en1 && (wr_addr1 == a)) d = wr_data1;
      if (is_zero(a) || rst) d = '0;
      return d;
   endfunction

   // A new issue overrides a same-cycle write-back: the newer producer is still outstanding.
   always_comb begin
      busy_d = '0;
      cnt_d  = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         busy_d[i] = (iss_en && (iss_addr == ADDR_W'(i)) && !is_zero(ADDR_W'(i)))
                     || (busy_q[i] && !wr_hit(ADDR_W'(i)));
         cnt_d     = cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) regs_q[i] <= '0;
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (wr_en0 && !is_zero(wr_addr0)) regs_q[wr_addr0] <= wr_data0;
         if (wr_en1 && !is_zero(wr_addr1)) regs_q[wr_addr1] <= wr_data1;
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   always_comb begin
      rd_data1 = read_data(rd_addr1);
      rd_data2 = read_data(rd_addr2);
      rd_eq    = (rd_data1 == rd_data2);
      rd_busy1 = busy_q[rd_addr1] && !(BYPASS && wr_hit(rd_addr1)) && !rst;
      rd_busy2 = busy_q[rd_addr2] && !(BYPASS && wr_hit(rd_addr2)) && !rst;
      busy_cnt = cnt_q;
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: default instance (zero reg, bypass) and a plain instance side by side.
module tb_regfile_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rd_addr1, rd_addr2, wr_addr0, wr_addr1, iss_addr;
   logic [31:0] wr_data0, wr_data1;
   logic        wr_en0, wr_en1, iss_en;

   logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2;
   logic        a_eq, a_busy1, a_busy2, b_eq, b_busy1, b_busy2;
   logic [5:0]  a_cnt, b_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   regfile_scoreboard dut (
      .clk(clk), .rst(rst), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(a_rd1), .rd_data2(a_rd2), .rd_eq(a_eq), .rd_busy1(a_busy1),
      .rd_busy2(a_busy2), .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
      .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1), .iss_en(iss_en),
      .iss_addr(iss_addr), .busy_cnt(a_cnt)
   );

   regfile_scoreboard #(.ZERO_REG(1'b0), .BYPASS(1'b0)) dut_nb (
      .clk(clk), .rst(rst), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(b_rd1), .rd_data2(b_rd2), .rd_eq(b_eq), .rd_busy1(b_busy1),
      .rd_busy2(b_busy2), .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
      .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1), .iss_en(iss_en),
      .iss_addr(iss_addr), .busy_cnt(b_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      wr_en0 = 1'b0; wr_en1 = 1'b0; iss_en = 1'b0;
      wr_addr0 = '0; wr_addr1 = '0; iss_addr = '0;
      wr_data0 = '0; wr_data1 = '0;
   endtask

   // Advance one edge, then drop all write/issue strobes.
   task automatic tick();
      @(posedge clk);
      #1;
      idle();
      #1;
   endtask

   initial begin
      rst = 1'b1;
      rd_addr1 = '0; rd_addr2 = '0;
      idle();
      #12;
      check("rst_rd1", a_rd1, 32'h0);
      check("rst_eq", {31'b0, a_eq}, 32'h1);
      check("rst_cnt", {26'b0, a_cnt}, 32'h0);
      check("rst_busy1", {31'b0, a_busy1}, 32'h0);
      rst = 1'b0;
      tick();

      // Test 1: reset wipes stored data and a pending write
      wr_en0 = 1'b1; wr_addr0 = 5'd5; wr_data0 = 32'h1234;
      iss_en = 1'b1; iss_addr = 5'd6;
      tick();
      rd_addr1 = 5'd5; rd_addr2 = 5'd6; #1;
      check("t1_r5", a_rd1, 32'h1234);
      check("t1_cnt", {26'b0, a_cnt}, 32'h1);
      check("t1_busy6", {31'b0, a_busy2}, 32'h1);
      wr_en0 = 1'b1; wr_addr0 = 5'd5; wr_data0 = 32'h99;
      rst = 1'b1; #1;
      check("t1_rst_rd1", a_rd1, 32'h0);
      check("t1_rst_cnt", {26'b0, a_cnt}, 32'h0);
      check("t1_rst_eq", {31'b0, a_eq}, 32'h1);
      check("t1_rst_busy", {31'b0, a_busy2}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0; idle(); #1;
      check("t1_lost_a", a_rd1, 32'h0);
      check("t1_lost_b", b_rd1, 32'h0);
      check("t1_busy_after", {31'b0, a_busy2}, 32'h0);

      // Test 2: bypass vs stored value
      wr_en0 = 1'b1; wr_addr0 = 5'd3; wr_data0 = 32'hDEADBEEF;
      rd_addr1 = 5'd3; #1;
      check("t2_byp", a_rd1, 32'hDEADBEEF);
      check("t2_nobyp", b_rd1, 32'h0);
      tick();
      check("t2_nb_next", b_rd1, 32'hDEADBEEF);

      // Test 3: dual write collision, port 1 wins
      wr_en0 = 1'b1; wr_addr0 = 5'd7; wr_data0 = 32'h11;
      wr_en1 = 1'b1; wr_addr1 = 5'd7; wr_data1 = 32'h22;
      rd_addr1 = 5'd7; #1;
      check("t3_byp", a_rd1, 32'h22);
      tick();
      check("t3_a", a_rd1, 32'h22);
      check("t3_b", b_rd1, 32'h22);

      // Test 4: register 0
      wr_en0 = 1'b1; wr_addr0 = 5'd0; wr_data0 = 32'hFFFF_FFFF;
      iss_en = 1'b1; iss_addr = 5'd0;
      rd_addr1 = 5'd0; #1;
      check("t4_byp_zero", a_rd1, 32'h0);
      tick();
      check("t4_a_rd", a_rd1, 32'h0);
      check("t4_a_busy", {31'b0, a_busy1}, 32'h0);
      check("t4_a_cnt", {26'b0, a_cnt}, 32'h0);
      check("t4_b_rd", b_rd1, 32'hFFFF_FFFF);
      check("t4_b_busy", {31'b0, b_busy1}, 32'h1);
      check("t4_b_cnt", {26'b0, b_cnt}, 32'h1);
      wr_en0 = 1'b1; wr_addr0 = 5'd0; wr_data0 = 32'hFFFF_FFFF;
      tick();
      check("t4_b_cnt_clr", {26'b0, b_cnt}, 32'h0);

      // Test 5: scoreboard set/clear, set-wins, re-issue
      iss_en = 1'b1; iss_addr = 5'd4;
      tick();
      iss_en = 1'b1; iss_addr = 5'd9;
      tick();
      rd_addr1 = 5'd4; rd_addr2 = 5'd9; #1;
      check("t5_cnt2", {26'b0, a_cnt}, 32'h2);
      check("t5_busy4", {31'b0, a_busy1}, 32'h1);
      check("t5_busy9", {31'b0, a_busy2}, 32'h1);
      iss_en = 1'b1; iss_addr = 5'd4;
      wr_en0 = 1'b1; wr_addr0 = 5'd4; wr_data0 = 32'h44; #1;
      check("t5_busy_byp", {31'b0, a_busy1}, 32'h0);
      check("t5_busy_nb", {31'b0, b_busy1}, 32'h1);
      tick();
      check("t5_setwins", {31'b0, a_busy1}, 32'h1);
      check("t5_cnt_keep", {26'b0, a_cnt}, 32'h2);
      iss_en = 1'b1; iss_addr = 5'd9;
      tick();
      check("t5_reissue", {26'b0, a_cnt}, 32'h2);
      wr_en0 = 1'b1; wr_addr0 = 5'd4; wr_data0 = 32'h44;
      wr_en1 = 1'b1; wr_addr1 = 5'd9; wr_data1 = 32'h99;
      tick();
      check("t5_cnt0", {26'b0, a_cnt}, 32'h0);
      check("t5_b_cnt0", {26'b0, b_cnt}, 32'h0);
      check("t5_free4", {31'b0, a_busy1}, 32'h0);
      check("t5_r9", a_rd2, 32'h99);

      // Test 6: equality flag, including bypassed data
      wr_en0 = 1'b1; wr_addr0 = 5'd1; wr_data0 = 32'h5;
      wr_en1 = 1'b1; wr_addr1 = 5'd2; wr_data1 = 32'h5;
      tick();
      rd_addr1 = 5'd1; rd_addr2 = 5'd2; #1;
      check("t6_eq", {31'b0, a_eq}, 32'h1);
      wr_en0 = 1'b1; wr_addr0 = 5'd2; wr_data0 = 32'h6; #1;
      check("t6_byp_ne", {31'b0, a_eq}, 32'h0);
      check("t6_byp_rd2", a_rd2, 32'h6);
      check("t6_nb_eq", {31'b0, b_eq}, 32'h1);
      tick();
      check("t6_nb_ne", {31'b0, b_eq}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
